// File: rtl/exp_decay_pkg.sv
// exp_decay_pkg: shared constants for the exponential decay lookup
package exp_decay_pkg;
  localparam int EXP_DECAY_W = 8;
  localparam int EXP_DECAY_HALF_LIFE = 32;
  localparam logic [EXP_DECAY_W-1:0] EXP_DECAY_MAX = 8'hFF;
endpackage

// File: rtl/eight_bit_exp_decay_lookup_if.sv
// eight_bit_exp_decay_lookup_if: phase-in / amplitude-out bus
//   din  : linear phase, 0 = start of decay, 255 = end
//   dout : decayed amplitude, 255 = full scale
//   master drives din, slave (the lookup) drives dout
interface eight_bit_exp_decay_lookup_if
  import exp_decay_pkg::*;
();
  logic [EXP_DECAY_W-1:0] din;
  logic [EXP_DECAY_W-1:0] dout;
  modport master (output din, input dout);
  modport slave (input din, output dout);
endinterface

// File: rtl/exp_decay_rom.sv
// exp_decay_rom: fixed table min(255, floor(256 * 2^(-x/32))), with 255 -> 0
//   din       : linear phase
//   table_out : decayed amplitude, combinational
module exp_decay_rom
  import exp_decay_pkg::*;
(
  input  logic [EXP_DECAY_W-1:0] din,
  output logic [EXP_DECAY_W-1:0] table_out
);
  // Each 32-entry block is the previous block halved (one half-life per block).
  always_comb begin
    case (din)
      8'd0:   table_out = EXP_DECAY_MAX; 8'd1:   table_out = 8'd250; 8'd2:   table_out = 8'd245; 8'd3:   table_out = 8'd239;
      8'd4:   table_out = 8'd234; 8'd5:   table_out = 8'd229; 8'd6:   table_out = 8'd224; 8'd7:   table_out = 8'd219;
      8'd8:   table_out = 8'd215; 8'd9:   table_out = 8'd210; 8'd10:  table_out = 8'd206; 8'd11:  table_out = 8'd201;
      8'd12:  table_out = 8'd197; 8'd13:  table_out = 8'd193; 8'd14:  table_out = 8'd189; 8'd15:  table_out = 8'd184;
      8'd16:  table_out = 8'd181; 8'd17:  table_out = 8'd177; 8'd18:  table_out = 8'd173; 8'd19:  table_out = 8'd169;
      8'd20:  table_out = 8'd165; 8'd21:  table_out = 8'd162; 8'd22:  table_out = 8'd158; 8'd23:  table_out = 8'd155;
      8'd24:  table_out = 8'd152; 8'd25:  table_out = 8'd148; 8'd26:  table_out = 8'd145; 8'd27:  table_out = 8'd142;
      8'd28:  table_out = 8'd139; 8'd29:  table_out = 8'd136; 8'd30:  table_out = 8'd133; 8'd31:  table_out = 8'd130;
      8'd32:  table_out = 8'd128; 8'd33:  table_out = 8'd125; 8'd34:  table_out = 8'd122; 8'd35:  table_out = 8'd119;
      8'd36:  table_out = 8'd117; 8'd37:  table_out = 8'd114; 8'd38:  table_out = 8'd112; 8'd39:  table_out = 8'd109;
      8'd40:  table_out = 8'd107; 8'd41:  table_out = 8'd105; 8'd42:  table_out = 8'd103; 8'd43:  table_out = 8'd100;
      8'd44:  table_out = 8'd98;  8'd45:  table_out = 8'd96;  8'd46:  table_out = 8'd94;  8'd47:  table_out = 8'd92;
      8'd48:  table_out = 8'd90;  8'd49:  table_out = 8'd88;  8'd50:  table_out = 8'd86;  8'd51:  table_out = 8'd84;
      8'd52:  table_out = 8'd82;  8'd53:  table_out = 8'd81;  8'd54:  table_out = 8'd79;  8'd55:  table_out = 8'd77;
      8'd56:  table_out = 8'd76;  8'd57:  table_out = 8'd74;  8'd58:  table_out = 8'd72;  8'd59:  table_out = 8'd71;
      8'd60:  table_out = 8'd69;  8'd61:  table_out = 8'd68;  8'd62:  table_out = 8'd66;  8'd63:  table_out = 8'd65;
      8'd64:  table_out = 8'd64;  8'd65:  table_out = 8'd62;  8'd66:  table_out = 8'd61;  8'd67:  table_out = 8'd59;
      8'd68:  table_out = 8'd58;  8'd69:  table_out = 8'd57;  8'd70:  table_out = 8'd56;  8'd71:  table_out = 8'd54;
      8'd72:  table_out = 8'd53;  8'd73:  table_out = 8'd52;  8'd74:  table_out = 8'd51;  8'd75:  table_out = 8'd50;
      8'd76:  table_out = 8'd49;  8'd77:  table_out = 8'd48;  8'd78:  table_out = 8'd47;  8'd79:  table_out = 8'd46;
      8'd80:  table_out = 8'd45;  8'd81:  table_out = 8'd44;  8'd82:  table_out = 8'd43;  8'd83:  table_out = 8'd42;
      8'd84:  table_out = 8'd41;  8'd85:  table_out = 8'd40;  8'd86:  table_out = 8'd39;  8'd87:  table_out = 8'd38;
      8'd88:  table_out = 8'd38;  8'd89:  table_out = 8'd37;  8'd90:  table_out = 8'd36;  8'd91:  table_out = 8'd35;
      8'd92:  table_out = 8'd34;  8'd93:  table_out = 8'd34;  8'd94:  table_out = 8'd33;  8'd95:  table_out = 8'd32;
      8'd96:  table_out = 8'd32;  8'd97:  table_out = 8'd31;  8'd98:  table_out = 8'd30;  8'd99:  table_out = 8'd29;
      8'd100: table_out = 8'd29;  8'd101: table_out = 8'd28;  8'd102: table_out = 8'd28;  8'd103: table_out = 8'd27;
      8'd104: table_out = 8'd26;  8'd105: table_out = 8'd26;  8'd106: table_out = 8'd25;  8'd107: table_out = 8'd25;
      8'd108: table_out = 8'd24;  8'd109: table_out = 8'd24;  8'd110: table_out = 8'd23;  8'd111: table_out = 8'd23;
      8'd112: table_out = 8'd22;  8'd113: table_out = 8'd22;  8'd114: table_out = 8'd21;  8'd115: table_out = 8'd21;
      8'd116: table_out = 8'd20;  8'd117: table_out = 8'd20;  8'd118: table_out = 8'd19;  8'd119: table_out = 8'd19;
      8'd120: table_out = 8'd19;  8'd121: table_out = 8'd18;  8'd122: table_out = 8'd18;  8'd123: table_out = 8'd17;
      8'd124: table_out = 8'd17;  8'd125: table_out = 8'd17;  8'd126: table_out = 8'd16;  8'd127: table_out = 8'd16;
      8'd128: table_out = 8'd16;  8'd129: table_out = 8'd15;  8'd130: table_out = 8'd15;  8'd131: table_out = 8'd14;
      8'd132: table_out = 8'd14;  8'd133: table_out = 8'd14;  8'd134: table_out = 8'd14;  8'd135: table_out = 8'd13;
      8'd136: table_out = 8'd13;  8'd137: table_out = 8'd13;  8'd138: table_out = 8'd12;  8'd139: table_out = 8'd12;
      8'd140: table_out = 8'd12;  8'd141: table_out = 8'd12;  8'd142: table_out = 8'd11;  8'd143: table_out = 8'd11;
      8'd144: table_out = 8'd11;  8'd145: table_out = 8'd11;  8'd146: table_out = 8'd10;  8'd147: table_out = 8'd10;
      8'd148: table_out = 8'd10;  8'd149: table_out = 8'd10;  8'd150: table_out = 8'd9;   8'd151: table_out = 8'd9;
      8'd152: table_out = 8'd9;   8'd153: table_out = 8'd9;   8'd154: table_out = 8'd9;   8'd155: table_out = 8'd8;
      8'd156: table_out = 8'd8;   8'd157: table_out = 8'd8;   8'd158: table_out = 8'd8;   8'd159: table_out = 8'd8;
      8'd160: table_out = 8'd8;   8'd161: table_out = 8'd7;   8'd162: table_out = 8'd7;   8'd163: table_out = 8'd7;
      8'd164: table_out = 8'd7;   8'd165: table_out = 8'd7;   8'd166: table_out = 8'd7;   8'd167: table_out = 8'd6;
      8'd168: table_out = 8'd6;   8'd169: table_out = 8'd6;   8'd170: table_out = 8'd6;   8'd171: table_out = 8'd6;
      8'd172: table_out = 8'd6;   8'd173: table_out = 8'd6;   8'd174: table_out = 8'd5;   8'd175: table_out = 8'd5;
      8'd176: table_out = 8'd5;   8'd177: table_out = 8'd5;   8'd178: table_out = 8'd5;   8'd179: table_out = 8'd5;
      8'd180: table_out = 8'd5;   8'd181: table_out = 8'd5;   8'd182: table_out = 8'd4;   8'd183: table_out = 8'd4;
      8'd184: table_out = 8'd4;   8'd185: table_out = 8'd4;   8'd186: table_out = 8'd4;   8'd187: table_out = 8'd4;
      8'd188: table_out = 8'd4;   8'd189: table_out = 8'd4;   8'd190: table_out = 8'd4;   8'd191: table_out = 8'd4;
      8'd192: table_out = 8'd4;   8'd193: table_out = 8'd3;   8'd194: table_out = 8'd3;   8'd195: table_out = 8'd3;
      8'd196: table_out = 8'd3;   8'd197: table_out = 8'd3;   8'd198: table_out = 8'd3;   8'd199: table_out = 8'd3;
      8'd200: table_out = 8'd3;   8'd201: table_out = 8'd3;   8'd202: table_out = 8'd3;   8'd203: table_out = 8'd3;
      8'd204: table_out = 8'd3;   8'd205: table_out = 8'd3;   8'd206: table_out = 8'd2;   8'd207: table_out = 8'd2;
      8'd208: table_out = 8'd2;   8'd209: table_out = 8'd2;   8'd210: table_out = 8'd2;   8'd211: table_out = 8'd2;
      8'd212: table_out = 8'd2;   8'd213: table_out = 8'd2;   8'd214: table_out = 8'd2;   8'd215: table_out = 8'd2;
      8'd216: table_out = 8'd2;   8'd217: table_out = 8'd2;   8'd218: table_out = 8'd2;   8'd219: table_out = 8'd2;
      8'd220: table_out = 8'd2;   8'd221: table_out = 8'd2;   8'd222: table_out = 8'd2;   8'd223: table_out = 8'd2;
      8'd224: table_out = 8'd2;   8'd225: table_out = 8'd1;   8'd226: table_out = 8'd1;   8'd227: table_out = 8'd1;
      8'd228: table_out = 8'd1;   8'd229: table_out = 8'd1;   8'd230: table_out = 8'd1;   8'd231: table_out = 8'd1;
      8'd232: table_out = 8'd1;   8'd233: table_out = 8'd1;   8'd234: table_out = 8'd1;   8'd235: table_out = 8'd1;
      8'd236: table_out = 8'd1;   8'd237: table_out = 8'd1;   8'd238: table_out = 8'd1;   8'd239: table_out = 8'd1;
      8'd240: table_out = 8'd1;   8'd241: table_out = 8'd1;   8'd242: table_out = 8'd1;   8'd243: table_out = 8'd1;
      8'd244: table_out = 8'd1;   8'd245: table_out = 8'd1;   8'd246: table_out = 8'd1;   8'd247: table_out = 8'd1;
      8'd248: table_out = 8'd1;   8'd249: table_out = 8'd1;   8'd250: table_out = 8'd1;   8'd251: table_out = 8'd1;
      8'd252: table_out = 8'd1;   8'd253: table_out = 8'd1;   8'd254: table_out = 8'd1;
      // Forced to silence so a release always ends at zero.
      8'd255: table_out = 8'd0;
      default: table_out = '0;
    endcase
  end
endmodule

// File: rtl/eight_bit_exp_decay_lookup.sv
// eight_bit_exp_decay_lookup: 8-bit linear phase to exponentially decaying amplitude
//   clk : sample-rate clock
//   rst : asynchronous active-low reset
//   bus : slave side, din = phase in, dout = amplitude out
//   EXP_DECAY_OUT_REG_EN defined: dout registered, 1-cycle latency, reset to 0
//   EXP_DECAY_OUT_REG_EN undefined: dout combinational, clk/rst unused
module eight_bit_exp_decay_lookup
  import exp_decay_pkg::*;
(
  input logic clk,
  input logic rst,
  eight_bit_exp_decay_lookup_if.slave bus
);
  logic [EXP_DECAY_W-1:0] table_out;
  exp_decay_rom u_rom (.din(bus.din), .table_out(table_out));
`ifdef EXP_DECAY_OUT_REG_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) bus.dout <= '0;
    else bus.dout <= table_out;
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk & rst;
  assign bus.dout = table_out;
`endif
endmodule

// File: tb/tb_eight_bit_exp_decay_lookup.sv
// tb_eight_bit_exp_decay_lookup: directed checks of the decay lookup in either build
module tb_eight_bit_exp_decay_lookup;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] anc_in [8] = '{8'd0, 8'd16, 8'd32, 8'd64, 8'd128, 8'd224, 8'd254, 8'd255};
  logic [7:0] anc_out [8] = '{8'd255, 8'd181, 8'd128, 8'd64, 8'd16, 8'd2, 8'd1, 8'd0};
  logic [7:0] prev;
  eight_bit_exp_decay_lookup_if bus ();
  eight_bit_exp_decay_lookup dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic logic [7:0] ref_val(int x);
    real r;
    if (x == 255) return 8'd0;
    r = $floor(256.0 * $pow(2.0, -x / 32.0));
    return r > 255.0 ? 8'd255 : 8'($rtoi(r));
  endfunction
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask
  task automatic step();
`ifdef EXP_DECAY_OUT_REG_EN
    @(negedge clk);
`else
    #1;
`endif
  endtask
  initial begin
    bus.din = 8'd0;
`ifdef EXP_DECAY_OUT_REG_EN
    #1 check("rst_async", bus.dout, 8'd0);
    repeat (3) @(negedge clk);
    check("rst_hold", bus.dout, 8'd0);
    rst = 1'b1;
    #1 check("rst_release_pre", bus.dout, 8'd0);
    @(negedge clk);
    check("rst_release", bus.dout, 8'd255);
    prev = 8'd255;
    for (int i = 0; i < 8; i++) begin
      bus.din = anc_in[i];
      #1 check("anchor_latency", bus.dout, prev);
      @(negedge clk);
      check($sformatf("anchor_%0d", anc_in[i]), bus.dout, anc_out[i]);
      prev = anc_out[i];
    end
`else
    rst = 1'b1;
    bus.din = 8'd96;
    #1 check("comb_96", bus.dout, 8'd32);
    repeat (3) @(posedge clk);
    #1 check("comb_clk_no_effect", bus.dout, 8'd32);
    rst = 1'b0;
    #1 check("comb_rst_no_effect", bus.dout, 8'd32);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.din = anc_in[i];
      #1 check($sformatf("anchor_%0d", anc_in[i]), bus.dout, anc_out[i]);
    end
`endif
    prev = 8'd255;
    for (int x = 0; x < 256; x++) begin
      bus.din = 8'(x);
      step();
      check($sformatf("sweep_%0d", x), bus.dout, ref_val(x));
      check($sformatf("monotonic_%0d", x), {7'd0, bus.dout <= prev}, 8'd1);
      prev = bus.dout;
    end
`ifdef EXP_DECAY_OUT_REG_EN
    bus.din = 8'd32;
    @(negedge clk);
    check("mid_pre_reset", bus.dout, 8'd128);
    #2 rst = 1'b0;
    #1 check("mid_async_drop", bus.dout, 8'd0);
    @(negedge clk);
    @(negedge clk);
    check("mid_reset_hold", bus.dout, 8'd0);
    rst = 1'b1;
    #1 check("mid_release_pre", bus.dout, 8'd0);
    @(negedge clk);
    check("mid_release", bus.dout, 8'd128);
`endif
    for (int i = 0; i < 8; i++) begin
      bus.din = i[0] ? 8'd255 : 8'd0;
      step();
      check($sformatf("alternate_%0d", i), bus.dout, i[0] ? 8'd0 : 8'd255);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
